pipeline_trace_monitor: RTL and testbench
=========================================

PIPELINE_TRACE_MONITOR -- requirements
Module: pipeline_trace_monitor

Interface
REQ-001 SHALL have parameter XLEN, default 32, meaning data/PC width.
REQ-002 SHALL have parameter DEPTH, default 16, meaning trace buffer entries; power of two, at least 2.
REQ-003 SHALL have parameter HANG_CYCLES, default 64, meaning consecutive cycles of unchanged fetch PC that declare a hang; at least 2.
REQ-004 SHALL have parameter OVERWRITE, default 0, meaning full-buffer policy: 0 drops the newest entry, 1 evicts the oldest.
REQ-005 SHALL have port Clk, input, 1, meaning the single clock; all state updates on its rising edge.
REQ-006 SHALL have port reset, input, 1, meaning asynchronous, active-low reset.
REQ-007 SHALL have port clear, input, 1, meaning synchronous soft clear.
REQ-008 SHALL have port wb_valid, input, 1, meaning the write-back stage writes a register this cycle (MEM_WB_RegWrite).
REQ-009 SHALL have port wb_rd, input, 5, meaning the write-back destination register.
REQ-010 SHALL have port wb_data, input, XLEN, meaning the write-back data.
REQ-011 SHALL have port wb_pc, input, XLEN, meaning the PC of the retiring instruction.
REQ-012 SHALL have port fetch_pc, input, XLEN, meaning the current fetch-stage PC.
REQ-013 SHALL have port rd_ready, input, 1, meaning the consumer accepts the head entry.
REQ-014 SHALL have port rd_valid, output, 1, meaning the head entry is available.
REQ-015 SHALL have ports rd_rd (5), rd_data (XLEN) and rd_pc (XLEN), outputs, meaning the head entry fields.
REQ-016 SHALL have port level, output, $clog2(DEPTH)+1, meaning the current entry count.
REQ-017 SHALL have ports retired_count (32) and cycle_count (32), outputs, meaning the statistics counters.
REQ-018 SHALL have ports overflow (1) and hang (1), outputs, meaning sticky status flags.

Function
REQ-019 SHALL push an entry {wb_rd, wb_data, wb_pc} only when wb_valid=1, wb_rd!=0 and the state is RUN; writes to x0 are ignored entirely.
REQ-020 SHALL present the head entry first-word-fall-through: rd_valid=(level!=0) with the head fields valid in the same cycle; a pop occurs when rd_valid and rd_ready are both 1.
REQ-021 SHALL, on a push and pop in the same cycle at any level including full, perform both operations, leave level unchanged and not set overflow.
REQ-022 SHALL, on a push into a full buffer with no pop, set overflow and, if OVERWRITE=0, discard the new entry, or, if OVERWRITE=1, write the new entry and advance the head so the oldest entry is lost; level stays DEPTH in both cases.
REQ-023 SHALL implement read/write pointers that wrap modulo DEPTH; level never exceeds DEPTH or underflows, and a pop when empty is ignored.
REQ-024 SHALL increment retired_count on every qualifying push attempt, including dropped ones, saturating at 0xFFFFFFFF.
REQ-025 SHALL increment cycle_count every cycle in RUN, saturating at 0xFFFFFFFF, and hold it in HUNG.
REQ-026 SHALL use FSM states RUN and HUNG; an internal stall counter resets to 0 whenever fetch_pc differs from its previous-cycle value, otherwise increments.
REQ-027 SHALL, when the stall counter reaches HANG_CYCLES-1 (fetch_pc unchanged for HANG_CYCLES consecutive cycles), enter HUNG and set hang on the next edge.
REQ-028 SHALL, in HUNG, stop all captures and counters while keeping the readout operational; HUNG exits only via clear or reset.
REQ-029 SHALL, on clear=1, set level=0, zero both pointers, both counters and the stall counter, clear overflow and hang, and enter RUN; clear takes priority over any same-cycle push or pop.

Reset
REQ-030 SHALL, with reset=0 regardless of Clk, drive level=0, rd_valid=0, retired_count=0, cycle_count=0, overflow=0, hang=0 and state RUN, with the previous-PC register at 0; stale buffer contents are never presented.
REQ-031 SHALL resume normal operation on the first rising edge after reset deasserts, and assertion mid-operation discards all entries.

Verification
REQ-032 Bench SHALL cover: 3 writebacks (rd=1,2,0) with rd_ready=0 -> level=2, retired_count=2, head rd_rd=1.
REQ-033 Bench SHALL cover: DEPTH+1 pushes with OVERWRITE=0 -> level=DEPTH, overflow=1, head equals the first entry; with OVERWRITE=1 -> head equals the second entry.
REQ-034 Bench SHALL cover: push and pop every cycle for 3*DEPTH cycles -> level constant, overflow=0, entries in order across the pointer wrap.
REQ-035 Bench SHALL cover: fetch_pc held constant for HANG_CYCLES cycles -> hang=1, cycle_count frozen, wb pushes ignored, readout still drains.
REQ-036 Bench SHALL cover: clear asserted together with push while HUNG -> next cycle level=0, hang=0, counters=0, state RUN.
REQ-037 Bench SHALL cover: reset asserted asynchronously mid-burst -> outputs zero immediately, before the next Clk edge.

Source files
------------

// File: rtl/pipeline_trace_monitor.sv
// rtl/pipeline_trace_monitor.sv - retirement trace FIFO with hang detection and statistics
module pipeline_trace_monitor #(
  parameter int XLEN        = 32,
  parameter int DEPTH       = 16,
  parameter int HANG_CYCLES = 64,
  parameter int OVERWRITE   = 0
) (
  input  logic                   Clk,
  input  logic                   reset,
  input  logic                   clear,
  input  logic                   wb_valid,
  input  logic [4:0]             wb_rd,
  input  logic [XLEN-1:0]        wb_data,
  input  logic [XLEN-1:0]        wb_pc,
  input  logic [XLEN-1:0]        fetch_pc,
  input  logic                   rd_ready,
  output logic                   rd_valid,
  output logic [4:0]             rd_rd,
  output logic [XLEN-1:0]        rd_data,
  output logic [XLEN-1:0]        rd_pc,
  output logic [$clog2(DEPTH):0] level,
  output logic [31:0]            retired_count,
  output logic [31:0]            cycle_count,
  output logic                   overflow,
  output logic                   hang
);

  localparam int PW = $clog2(DEPTH);
  localparam int LW = PW + 1;
  localparam int SW = $clog2(HANG_CYCLES) + 1;
  localparam int EW = 5 + 2 * XLEN;
  localparam logic [LW-1:0] FULL_LEVEL  = LW'(DEPTH);
  localparam logic [SW-1:0] STALL_LIMIT = SW'(HANG_CYCLES - 1);
  localparam bit            EVICT       = (OVERWRITE != 0);

  typedef enum logic [0:0] {RUN, HUNG} state_t;

  state_t          state;
  state_t          state_nxt;
  logic [EW-1:0]   mem [DEPTH];
  logic [PW-1:0]   wr_ptr;
  logic [PW-1:0]   rd_ptr;
  logic [SW-1:0]   stall;
  logic [XLEN-1:0] prev_pc;
  logic [EW-1:0]   head;
  logic            full;
  logic            push_req;
  logic            pop;
  logic            push_full_only;
  logic            do_write;
  logic            adv_rd;

  // A full buffer with a simultaneous pop still accepts the push; only an
  // unpaired push into a full buffer overflows (and may evict the head).
  assign rd_valid       = (level != '0);
  assign full           = (level == FULL_LEVEL);
  assign push_req       = (state == RUN) && wb_valid && (wb_rd != 5'd0);
  assign pop            = rd_valid && rd_ready;
  assign push_full_only = push_req && full && !pop;
  assign do_write       = push_req && (!full || pop || EVICT);
  assign adv_rd         = pop || (push_full_only && EVICT);
  assign hang           = (state == HUNG);

  // Head fields are gated so stale storage never appears on an empty buffer.
  assign head    = mem[rd_ptr];
  assign rd_rd   = rd_valid ? head[EW-1 -: 5]        : '0;
  assign rd_data = rd_valid ? head[2*XLEN-1 -: XLEN] : '0;
  assign rd_pc   = rd_valid ? head[XLEN-1:0]         : '0;

  // FSM state register.
  always_ff @(posedge Clk or negedge reset) begin
    if (!reset) state <= RUN;
    else        state <= state_nxt;
  end

  // Next state: hang once the PC has been stuck long enough; only clear leaves HUNG.
  always_comb begin
    state_nxt = state;
    if (clear)                                 state_nxt = RUN;
    else if (state == RUN && stall == STALL_LIMIT) state_nxt = HUNG;
  end

  // Trace storage; no reset needed because level gates what is visible.
  always_ff @(posedge Clk) begin
    if (do_write && !clear) mem[wr_ptr] <= {wb_rd, wb_data, wb_pc};
  end

  // Pointers, occupancy and the sticky overflow flag.
  always_ff @(posedge Clk or negedge reset) begin
    if (!reset) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      level    <= '0;
      overflow <= 1'b0;
    end else if (clear) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      level    <= '0;
      overflow <= 1'b0;
    end else begin
      if (do_write) wr_ptr <= wr_ptr + PW'(1);
      if (adv_rd)   rd_ptr <= rd_ptr + PW'(1);
      if (push_req && !full && !pop)   level <= level + LW'(1);
      else if (pop && !push_req)       level <= level - LW'(1);
      if (push_full_only) overflow <= 1'b1;
    end
  end

  // Saturating statistics, frozen while hung.
  always_ff @(posedge Clk or negedge reset) begin
    if (!reset) begin
      retired_count <= '0;
      cycle_count   <= '0;
    end else if (clear) begin
      retired_count <= '0;
      cycle_count   <= '0;
    end else if (state == RUN) begin
      if (cycle_count != 32'hFFFF_FFFF) cycle_count <= cycle_count + 32'd1;
      if (push_req && retired_count != 32'hFFFF_FFFF) retired_count <= retired_count + 32'd1;
    end
  end

  // Stall counter tracks how long the fetch PC has stayed put.
  always_ff @(posedge Clk or negedge reset) begin
    if (!reset) begin
      stall   <= '0;
      prev_pc <= '0;
    end else begin
      prev_pc <= fetch_pc;
      if (clear)                     stall <= '0;
      else if (state == RUN) begin
        if (fetch_pc != prev_pc)     stall <= '0;
        else                         stall <= stall + SW'(1);
      end
    end
  end

endmodule

// File: tb/tb_pipeline_trace_monitor.sv
// tb/tb_pipeline_trace_monitor.sv - randomized bench with queue model for both full-buffer policies
module tb_pipeline_trace_monitor;

  localparam int XLEN  = 32;
  localparam int DEPTH = 4;
  localparam int HANG  = 8;
  localparam int LW    = $clog2(DEPTH) + 1;
  localparam longint unsigned SAT = 64'hFFFF_FFFF;

  logic            Clk = 1'b0;
  logic            reset = 1'b0;
  logic            clear = 1'b0;
  logic            wb_valid = 1'b0;
  logic [4:0]      wb_rd = '0;
  logic [XLEN-1:0] wb_data = '0;
  logic [XLEN-1:0] wb_pc = '0;
  logic [XLEN-1:0] fetch_pc = '0;
  logic            rd_ready = 1'b0;

  logic            rd_valid_o [2];
  logic [4:0]      rd_rd_o    [2];
  logic [XLEN-1:0] rd_data_o  [2];
  logic [XLEN-1:0] rd_pc_o    [2];
  logic [LW-1:0]   level_o    [2];
  logic [31:0]     retired_o  [2];
  logic [31:0]     cycles_o   [2];
  logic            overflow_o [2];
  logic            hang_o     [2];

  pipeline_trace_monitor #(.XLEN(XLEN), .DEPTH(DEPTH), .HANG_CYCLES(HANG), .OVERWRITE(0)) u_dut0 (
    .Clk(Clk), .reset(reset), .clear(clear), .wb_valid(wb_valid), .wb_rd(wb_rd),
    .wb_data(wb_data), .wb_pc(wb_pc), .fetch_pc(fetch_pc), .rd_ready(rd_ready),
    .rd_valid(rd_valid_o[0]), .rd_rd(rd_rd_o[0]), .rd_data(rd_data_o[0]), .rd_pc(rd_pc_o[0]),
    .level(level_o[0]), .retired_count(retired_o[0]), .cycle_count(cycles_o[0]),
    .overflow(overflow_o[0]), .hang(hang_o[0])
  );

  pipeline_trace_monitor #(.XLEN(XLEN), .DEPTH(DEPTH), .HANG_CYCLES(HANG), .OVERWRITE(1)) u_dut1 (
    .Clk(Clk), .reset(reset), .clear(clear), .wb_valid(wb_valid), .wb_rd(wb_rd),
    .wb_data(wb_data), .wb_pc(wb_pc), .fetch_pc(fetch_pc), .rd_ready(rd_ready),
    .rd_valid(rd_valid_o[1]), .rd_rd(rd_rd_o[1]), .rd_data(rd_data_o[1]), .rd_pc(rd_pc_o[1]),
    .level(level_o[1]), .retired_count(retired_o[1]), .cycle_count(cycles_o[1]),
    .overflow(overflow_o[1]), .hang(hang_o[1])
  );

  always #5 Clk = ~Clk;

  int n_checks = 0;
  int n_fail   = 0;
  bit check_en = 1'b0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Behavioural model: one entry queue per instance (index = OVERWRITE value).
  typedef struct packed {
    logic [4:0]      rd;
    logic [XLEN-1:0] data;
    logic [XLEN-1:0] pc;
  } entry_t;

  entry_t          m_q [2][$];
  bit              m_ovf [2];
  longint unsigned m_retired;
  longint unsigned m_cycles;
  bit              m_hung;
  int              m_run;
  logic [XLEN-1:0] m_last;
  bit              m_push;
  entry_t          m_e;

  always @(posedge Clk or negedge reset) begin
    if (!reset || clear) begin
      for (int k = 0; k < 2; k++) begin
        m_q[k].delete();
        m_ovf[k] = 1'b0;
      end
      m_retired = 0;
      m_cycles  = 0;
      m_hung    = 1'b0;
      m_run     = 1;
      m_last    = !reset ? '0 : fetch_pc;
    end else begin
      m_push  = !m_hung && wb_valid && (wb_rd != 5'd0);
      m_e.rd   = wb_rd;
      m_e.data = wb_data;
      m_e.pc   = wb_pc;
      for (int k = 0; k < 2; k++) begin
        if (m_q[k].size() > 0 && rd_ready) void'(m_q[k].pop_front());
        if (m_push) begin
          if (m_q[k].size() < DEPTH) m_q[k].push_back(m_e);
          else begin
            m_ovf[k] = 1'b1;
            if (k == 1) begin
              void'(m_q[k].pop_front());
              m_q[k].push_back(m_e);
            end
          end
        end
      end
      if (m_push && m_retired < SAT) m_retired++;
      if (!m_hung) begin
        if (m_cycles < SAT) m_cycles++;
        if (m_run >= HANG) m_hung = 1'b1;
        else begin
          if (fetch_pc == m_last) m_run++;
          else                    m_run = 1;
          m_last = fetch_pc;
        end
      end
    end
  end

  // Every cycle, compare both instances against the model.
  always begin
    @(posedge Clk);
    #1;
    if (check_en) begin
      for (int k = 0; k < 2; k++) begin
        check($sformatf("level[%0d]", k), level_o[k], m_q[k].size());
        check($sformatf("rd_valid[%0d]", k), rd_valid_o[k], m_q[k].size() != 0);
        if (m_q[k].size() != 0) begin
          check($sformatf("rd_rd[%0d]", k), rd_rd_o[k], m_q[k][0].rd);
          check($sformatf("rd_data[%0d]", k), rd_data_o[k], m_q[k][0].data);
          check($sformatf("rd_pc[%0d]", k), rd_pc_o[k], m_q[k][0].pc);
        end
        check($sformatf("retired[%0d]", k), retired_o[k], m_retired);
        check($sformatf("cycles[%0d]", k), cycles_o[k], m_cycles);
        check($sformatf("overflow[%0d]", k), overflow_o[k], m_ovf[k]);
        check($sformatf("hang[%0d]", k), hang_o[k], m_hung);
      end
    end
  end

  task automatic step(input bit clr, input bit v, input logic [4:0] rd, input logic [31:0] d,
                      input bit rdy, input bit hold);
    @(negedge Clk);
    clear    = clr;
    wb_valid = v;
    wb_rd    = rd;
    wb_data  = d;
    wb_pc    = $urandom;
    rd_ready = rdy;
    if (!hold) fetch_pc = fetch_pc + 32'd4;
  endtask

  task automatic rand_steps(input int n, input int clear_odds);
    for (int i = 0; i < n; i++) begin
      step($urandom_range(0, clear_odds) == 0, $urandom_range(0, 3) != 0,
           ($urandom_range(0, 4) == 0) ? 5'd0 : 5'($urandom_range(1, 31)),
           $urandom, $urandom_range(0, 1) == 1, $urandom_range(0, 2) == 0);
    end
  endtask

  logic [31:0] saved_cyc;
  logic [31:0] saved_ret;
  logic [LW-1:0] saved_lvl;

  initial begin
    repeat (2) @(negedge Clk);
    check_en = 1'b1;
    for (int k = 0; k < 2; k++) begin
      check($sformatf("rst_level[%0d]", k), level_o[k], 0);
      check($sformatf("rst_valid[%0d]", k), rd_valid_o[k], 0);
      check($sformatf("rst_hang[%0d]", k), hang_o[k], 0);
    end
    reset = 1'b1;

    // Three writebacks, one to x0, nothing consumed.
    step(0, 1, 5'd1, 32'h11, 0, 0);
    step(0, 1, 5'd2, 32'h22, 0, 0);
    step(0, 1, 5'd0, 32'h33, 0, 0);
    step(0, 0, 5'd0, 0, 0, 0);
    for (int k = 0; k < 2; k++) begin
      check($sformatf("x0_level[%0d]", k), level_o[k], 2);
      check($sformatf("x0_retired[%0d]", k), retired_o[k], 2);
      check($sformatf("x0_head_rd[%0d]", k), rd_rd_o[k], 1);
      check($sformatf("x0_head_data[%0d]", k), rd_data_o[k], 32'h11);
    end
    repeat (3) step(0, 0, 5'd0, 0, 1, 0);

    // DEPTH+1 pushes into a non-draining buffer.
    step(1, 0, 5'd0, 0, 0, 0);
    for (int i = 0; i <= DEPTH; i++) step(0, 1, 5'(i + 1), 32'd100 + 32'(i), 0, 0);
    step(0, 0, 5'd0, 0, 0, 0);
    for (int k = 0; k < 2; k++) begin
      check($sformatf("ovf_level[%0d]", k), level_o[k], DEPTH);
      check($sformatf("ovf_flag[%0d]", k), overflow_o[k], 1);
      check($sformatf("ovf_retired[%0d]", k), retired_o[k], DEPTH + 1);
    end
    check("ovf_head_drop", rd_data_o[0], 100);
    check("ovf_head_evict", rd_data_o[1], 101);
    repeat (DEPTH + 1) step(0, 0, 5'd0, 0, 1, 0);

    // Fill, then push and pop together every cycle across several pointer wraps.
    step(1, 0, 5'd0, 0, 0, 0);
    for (int i = 0; i < DEPTH; i++) step(0, 1, 5'(i + 1), 32'd300 + 32'(i), 0, 0);
    for (int i = 0; i < 3 * DEPTH; i++) step(0, 1, 5'((i % 31) + 1), 32'd200 + 32'(i), 1, 0);
    step(0, 0, 5'd0, 0, 0, 0);
    for (int k = 0; k < 2; k++) begin
      check($sformatf("wrap_level[%0d]", k), level_o[k], DEPTH);
      check($sformatf("wrap_ovf[%0d]", k), overflow_o[k], 0);
      check($sformatf("wrap_head[%0d]", k), rd_data_o[k], 200 + 2 * DEPTH);
    end
    repeat (DEPTH) step(0, 0, 5'd0, 0, 1, 0);

    rand_steps(300, 60);

    // Hold the fetch PC until the monitor declares a hang.
    step(1, 0, 5'd0, 0, 0, 0);
    for (int i = 0; i < 3; i++) step(0, 1, 5'd4, 32'd400 + 32'(i), 0, 0);
    repeat (HANG + 3) step(0, 1, 5'd7, $urandom, 0, 1);
    step(0, 0, 5'd0, 0, 0, 1);
    check("hang_set", hang_o[0], 1);
    saved_cyc = cycles_o[0];
    saved_ret = retired_o[0];
    saved_lvl = level_o[0];
    repeat (3) step(0, 1, 5'd9, $urandom, 0, 1);
    check("hang_cycles_frozen", cycles_o[0], saved_cyc);
    check("hang_retired_frozen", retired_o[0], saved_ret);
    check("hang_level_frozen", level_o[0], saved_lvl);
    repeat (DEPTH) step(0, 1, 5'd9, $urandom, 1, 1);
    step(0, 0, 5'd0, 0, 0, 1);
    check("hang_drained", level_o[0], 0);
    check("hang_still", hang_o[1], 1);

    // Clear wins over a same-cycle push while hung.
    step(1, 1, 5'd5, 32'h55, 0, 1);
    step(0, 0, 5'd0, 0, 0, 0);
    for (int k = 0; k < 2; k++) begin
      check($sformatf("clr_level[%0d]", k), level_o[k], 0);
      check($sformatf("clr_hang[%0d]", k), hang_o[k], 0);
      check($sformatf("clr_retired[%0d]", k), retired_o[k], 0);
      check($sformatf("clr_cycles[%0d]", k), cycles_o[k], 0);
    end
    step(0, 0, 5'd0, 0, 0, 0);
    check("clr_run_counting", cycles_o[0], 1);

    rand_steps(40, 1000);

    // Asynchronous reset in the middle of a burst.
    step(0, 1, 5'd3, 32'h77, 0, 0);
    step(0, 1, 5'd3, 32'h78, 0, 0);
    #7;
    check("pre_reset_nonempty", level_o[0] != 0, 1);
    reset = 1'b0;
    #1;
    for (int k = 0; k < 2; k++) begin
      check($sformatf("arst_level[%0d]", k), level_o[k], 0);
      check($sformatf("arst_valid[%0d]", k), rd_valid_o[k], 0);
      check($sformatf("arst_retired[%0d]", k), retired_o[k], 0);
      check($sformatf("arst_cycles[%0d]", k), cycles_o[k], 0);
      check($sformatf("arst_ovf[%0d]", k), overflow_o[k], 0);
    end
    @(negedge Clk);
    wb_valid = 1'b0;
    reset    = 1'b1;

    rand_steps(60, 1000);
    repeat (2) step(0, 0, 5'd0, 0, 0, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
